// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } state_t;

   localparam int BANK_LSB  = 16;
   localparam int BANK_BITS = 2;
   localparam int NUM_REQ   = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to rr_ptr.
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic               rr_ptr,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      grant    = '0;
      grant[0] = valid[0] && (!valid[1] || !rr_ptr);
      grant[1] = valid[1] && (!valid[0] ||  rr_ptr);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the banked data-memory port between the pipeline (req0) and the key loader (req1).
// Define MEM_PORT_ARBITER_BANK_CHECK_EN to suppress out-of-range writes and flag them on bank_err.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N        = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic         req0_we,
   input  logic         req0_lock,
   input  logic [N-1:0] req0_addr,
   input  logic [N-1:0] req0_wdata,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic         req1_we,
   input  logic         req1_lock,
   input  logic [N-1:0] req1_addr,
   input  logic [N-1:0] req1_wdata,
   output logic         req1_ready,
   output logic         rsp0_valid,
   output logic [N-1:0] rsp0_rdata,
   output logic         rsp1_valid,
   output logic [N-1:0] rsp1_rdata,
   output logic         mem_write_enable,
   output logic [N-1:0] mem_address,
   output logic [N-1:0] mem_write_data,
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
   output logic         bank_err,
`endif
   input  logic [N-1:0] mem_read_data
);

   localparam int LOCK_W = $clog2(MAX_LOCK);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

   state_t              state;
   logic                rr_ptr;
   logic [LOCK_W-1:0]   lock_cnt;
   logic [NUM_REQ-1:0]  pick;
   logic [NUM_REQ-1:0]  grant;
   logic                sel1;
   logic                sel_we;
   logic                sel_lock;
   logic                out_of_range;
   logic [N-1:0]        rd_data;

   mem_port_arbiter_rr_pick u_pick (
      .valid  ({req1_valid, req0_valid}),
      .rr_ptr (rr_ptr),
      .grant  (pick)
   );

   // Grants are held off during reset so nothing completes or writes memory.
   always_comb begin
      grant = '0;
      if (!rst) begin
         case (state)
            IDLE:    grant = pick;
            LOCK0:   grant = {1'b0, req0_valid};
            LOCK1:   grant = {req1_valid, 1'b0};
            default: grant = '0;
         endcase
      end
   end

   assign req0_ready     = grant[0];
   assign req1_ready     = grant[1];
   assign sel1           = grant[1];
   assign sel_we         = sel1 ? req1_we   : req0_we;
   assign sel_lock       = sel1 ? req1_lock : req0_lock;
   assign mem_address    = sel1 ? req1_addr  : req0_addr;
   assign mem_write_data = sel1 ? req1_wdata : req0_wdata;

`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
   assign out_of_range     = |mem_address[N-1:BANK_LSB+BANK_BITS];
   assign mem_write_enable = (|grant) && sel_we && !out_of_range;
   assign rd_data          = out_of_range ? '0 : mem_read_data;
`else
   assign out_of_range     = 1'b0;
   assign mem_write_enable = (|grant) && sel_we;
   assign rd_data          = mem_read_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         lock_cnt   <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
         bank_err   <= 1'b0;
`endif
      end else begin
         rsp0_valid <= grant[0] && !req0_we;
         rsp1_valid <= grant[1] && !req1_we;
         if (grant[0] && !req0_we) rsp0_rdata <= rd_data;
         if (grant[1] && !req1_we) rsp1_rdata <= rd_data;
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
         if ((|grant) && out_of_range) bank_err <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (|grant) begin
                  rr_ptr <= !sel1;
                  if (sel_lock) begin
                     state    <= sel1 ? LOCK1 : LOCK0;
                     lock_cnt <= '0;
                  end
               end
            end
            LOCK0: begin
               lock_cnt <= lock_cnt + LOCK_W'(1);
               if (!req0_valid || (grant[0] && !req0_lock) || lock_cnt == LOCK_LAST) begin
                  state    <= IDLE;
                  rr_ptr   <= 1'b1;
                  lock_cnt <= '0;
               end
            end
            LOCK1: begin
               lock_cnt <= lock_cnt + LOCK_W'(1);
               if (!req1_valid || (grant[1] && !req1_lock) || lock_cnt == LOCK_LAST) begin
                  state    <= IDLE;
                  rr_ptr   <= 1'b0;
                  lock_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory behind the port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_we, req0_lock;
   logic [31:0] req0_addr, req0_wdata;
   logic        req0_ready;
   logic        req1_valid, req1_we, req1_lock;
   logic [31:0] req1_addr, req1_wdata;
   logic        req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_write_enable;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
   logic        bank_err;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N(32), .MAX_LOCK(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .req0_valid       (req0_valid),
      .req0_we          (req0_we),
      .req0_lock        (req0_lock),
      .req0_addr        (req0_addr),
      .req0_wdata       (req0_wdata),
      .req0_ready       (req0_ready),
      .req1_valid       (req1_valid),
      .req1_we          (req1_we),
      .req1_lock        (req1_lock),
      .req1_addr        (req1_addr),
      .req1_wdata       (req1_wdata),
      .req1_ready       (req1_ready),
      .rsp0_valid       (rsp0_valid),
      .rsp0_rdata       (rsp0_rdata),
      .rsp1_valid       (rsp1_valid),
      .rsp1_rdata       (rsp1_rdata),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
      .bank_err         (bank_err),
`endif
      .mem_read_data    (mem_read_data)
   );

   // Unwritten words read back as A5A5_<addr[15:0]>; nonexistent banks read 0.
   logic [31:0] mem [256];
   bit          written [256];

   function automatic logic [7:0] idx(input logic [31:0] a);
      return {a[17:16], a[5:0]};
   endfunction

   always @(posedge clk) begin
      if (mem_write_enable && mem_address[31:18] == 14'd0) begin
         mem[idx(mem_address)]     <= mem_write_data;
         written[idx(mem_address)] <= 1'b1;
      end
   end

   always_comb begin
      mem_read_data = '0;
      if (mem_address[31:18] != 14'd0)
         mem_read_data = '0;
      else if (written[idx(mem_address)])
         mem_read_data = mem[idx(mem_address)];
      else
         mem_read_data = {16'hA5A5, mem_address[15:0]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0;
      req0_addr = 32'h0001_0004; req0_wdata = '0;
      req1_valid = 1'b1; req1_we = 1'b1; req1_lock = 1'b0;
      req1_addr = 32'h0001_0008; req1_wdata = 32'h5555_AAAA;

      // Reset held two cycles with requests pending
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_ready0", {31'd0, req0_ready}, 32'd0);
         check("rst_ready1", {31'd0, req1_ready}, 32'd0);
         check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
         check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
         check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
         check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
      end
      rst = 1'b0; req1_valid = 1'b0; #1;
      check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0; #1;
      check("post_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("post_rst_rsp0_rdata", rsp0_rdata, 32'hA5A5_0004);
      tick();
      check("post_rst_rsp0_pulse", {31'd0, rsp0_valid}, 32'd0);

      // Write by req1, read back by req0 (rr_ptr is 1 here)
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h0002_0010; req1_wdata = 32'hDEAD_BEEF; #1;
      check("wr_ready1", {31'd0, req1_ready}, 32'd1);
      check("wr_mem_we", {31'd0, mem_write_enable}, 32'd1);
      check("wr_mem_addr", mem_address, 32'h0002_0010);
      check("wr_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0002_0010; #1;
      check("rd_ready0", {31'd0, req0_ready}, 32'd1);
      check("rd_mem_we", {31'd0, mem_write_enable}, 32'd0);
      check("rd_rsp0_before", {31'd0, rsp0_valid}, 32'd0);
      tick();
      req0_valid = 1'b0; #1;
      check("rd_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
      check("rd_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
      tick();
      check("rd_rsp0_pulse", {31'd0, rsp0_valid}, 32'd0);

      // Round robin: rr_ptr is 1, so req1 wins first and grants alternate
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0100;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0000_0200;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("rr_ready1_%0d", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_ready0_%0d", i), {31'd0, req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check($sformatf("rr_rsp1_%0d", i), {31'd0, rsp1_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_rsp0_%0d", i), {31'd0, rsp0_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i % 2 == 0) check($sformatf("rr_rdata1_%0d", i), rsp1_rdata, 32'hA5A5_0200);
         else            check($sformatf("rr_rdata0_%0d", i), rsp0_rdata, 32'hA5A5_0100);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Lock hold: req1 locked burst while req0 waits (rr_ptr is 1)
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0100;
      req1_valid = 1'b1; req1_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req1_addr  = 32'h0003_0000 + 32'(i);
         req1_wdata = 32'hC0DE_0000 + 32'(i);
         req1_lock  = (i < 3);
         #1;
         check($sformatf("lk_ready1_%0d", i), {31'd0, req1_ready}, 32'd1);
         check($sformatf("lk_ready0_%0d", i), {31'd0, req0_ready}, 32'd0);
         check($sformatf("lk_mem_addr_%0d", i), mem_address, 32'h0003_0000 + 32'(i));
         check($sformatf("lk_mem_we_%0d", i), {31'd0, mem_write_enable}, 32'd1);
         tick();
      end
      req1_valid = 1'b0; req1_lock = 1'b0; #1;
      check("lk_release_ready0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0; #1;
      check("lk_release_rsp0", {31'd0, rsp0_valid}, 32'd1);
      tick();

      // Lock timeout: IDLE grant, 16 cycles in LOCK1, then req0, then req1 relocks
      req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 32'h0000_0100;
      req1_valid = 1'b1; req1_we = 1'b1; req1_lock = 1'b1;
      req1_addr = 32'h0003_0010; req1_wdata = 32'h0BAD_F00D;
      for (int c = 0; c < 20; c++) begin
         #1;
         check($sformatf("to_ready1_%0d", c), {31'd0, req1_ready}, (c == 17) ? 32'd0 : 32'd1);
         check($sformatf("to_ready0_%0d", c), {31'd0, req0_ready}, (c == 17) ? 32'd1 : 32'd0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; req1_lock = 1'b0;
      tick();
      tick();

      // Readback of a locked-burst word
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0003_0002; #1;
      check("rb_ready1", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0; #1;
      check("rb_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("rb_rsp1_rdata", rsp1_rdata, 32'hC0DE_0002);
      tick();

      // Nonexistent bank access
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h0004_0000; req0_wdata = 32'h1234_5678; #1;
      check("bk_ready0", {31'd0, req0_ready}, 32'd1);
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
      check("bk_mem_we", {31'd0, mem_write_enable}, 32'd0);
`else
      check("bk_mem_we", {31'd0, mem_write_enable}, 32'd1);
`endif
      tick();
      req0_we = 1'b0; #1;
      check("bk_rd_ready0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0; #1;
      check("bk_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("bk_rsp0_rdata", rsp0_rdata, 32'd0);
`ifdef MEM_PORT_ARBITER_BANK_CHECK_EN
      check("bk_err_set", {31'd0, bank_err}, 32'd1);
      tick();
      tick();
      check("bk_err_sticky", {31'd0, bank_err}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      check("bk_err_cleared", {31'd0, bank_err}, 32'd0);
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
